// File: rtl/gpr_pkg.sv
// Shared defaults and types for the multi-port general-purpose register file.
package gpr_pkg;
    localparam int GPR_XLEN  = 32;
    localparam int GPR_NREGS = 32;
    localparam int GPR_AW    = $clog2(GPR_NREGS);

    typedef logic [GPR_AW-1:0]   reg_addr_t;
    typedef logic [GPR_XLEN-1:0] reg_data_t;
endpackage

// File: rtl/gpr_multiport_if.sv
// Decode/writeback-facing bus of the register file: write ports, read ports, issue and hazard status.
interface gpr_multiport_if import gpr_pkg::*; #(
    parameter int XLEN  = GPR_XLEN,
    parameter int NREGS = GPR_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]           we;
    logic [NWR-1:0][AW-1:0]   wa;
    logic [NWR-1:0][XLEN-1:0] wd;
    logic [NRD-1:0][AW-1:0]   ra;
    logic [NRD-1:0][XLEN-1:0] rd;
    logic                     issue_valid;
    logic [AW-1:0]            issue_rd;
    logic [NRD-1:0]           rd_used;
    logic [NRD-1:0]           busy;
    logic                     stall;

    modport master (output we, wa, wd, ra, issue_valid, issue_rd, rd_used,
                    input  rd, busy, stall);
    modport slave  (input  we, wa, wd, ra, issue_valid, issue_rd, rd_used,
                    output rd, busy, stall);
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: set on issue, cleared by the Writeback port, exposed as busy/stall.
module gpr_scoreboard import gpr_pkg::*; #(
    parameter int NREGS    = GPR_NREGS,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_wa,
    input  logic [NRD-1:0][AW-1:0] ra,
    input  logic [NRD-1:0]         rd_used,
    output logic [NRD-1:0]         busy,
    output logic                   stall
);
    logic [NREGS-1:0] pending;
    logic             set_ok;

    assign set_ok = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));

    // Set is applied after clear so a fresh producer supersedes a retiring one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            if (wb_we)  pending[wb_wa]    <= 1'b0;
            if (set_ok) pending[issue_rd] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_busy
        assign busy[i] = pending[ra[i]] &
                         ~((BYPASS != 0) && wb_we && (wb_wa == ra[i]));
    end

    assign stall = |(busy & rd_used);
endmodule

// File: rtl/gpr_multiport.sv
// NRD-read / NWR-write register file with fixed write priority, optional bypass and hardwired x0.
module gpr_multiport import gpr_pkg::*; #(
    parameter int XLEN     = GPR_XLEN,
    parameter int NREGS    = GPR_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    gpr_multiport_if.slave  bus
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NWR-1:0]             wv;

    // Writes to x0 are squashed up front so neither storage nor bypass sees them.
    always_comb begin
        wv = '0;
        for (int p = 0; p < NWR; p++)
            wv[p] = bus.we[p] && !((ZERO_REG != 0) && (bus.wa[p] == '0));
    end

    // Port 0 is assigned last, so on an address collision it is the one that sticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs <= '0;
        end else begin
            for (int p = NWR - 1; p >= 0; p--)
                if (wv[p]) regs[bus.wa[p]] <= bus.wd[p];
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic            hit;
        logic [XLEN-1:0] byp;

        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int p = NWR - 1; p >= 0; p--) begin
                if (wv[p] && (bus.wa[p] == bus.ra[i])) begin
                    hit = 1'b1;
                    byp = bus.wd[p];
                end
            end
        end

        assign bus.rd[i] = ((BYPASS != 0) && hit) ? byp : regs[bus.ra[i]];
    end

    gpr_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .wb_we       (bus.we[NWR-1]),
        .wb_wa       (bus.wa[NWR-1]),
        .ra          (bus.ra),
        .rd_used     (bus.rd_used),
        .busy        (bus.busy),
        .stall       (bus.stall)
    );
endmodule

// File: tb/tb_gpr_multiport.sv
// Directed self-checking bench for gpr_multiport with default parameters (2R/2W, bypass, x0 hardwired).
module tb_gpr_multiport;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int BYPASS = 1;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    gpr_multiport_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    gpr_multiport #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we          = '0;
        bus.wa          = '0;
        bus.wd          = '0;
        bus.ra          = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rd_used     = '0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.we    = 2'b11;
        bus.wa[0] = 5'd1;
        bus.wa[1] = 5'd1;
        bus.wd[0] = 32'hAAAAAAAA;
        bus.wd[1] = 32'hAAAAAAAA;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd1;
        cyc();
        cyc();
        reset = 1'b1;
        idle();
        bus.ra[0] = 5'd0;
        bus.ra[1] = 5'd1;
        bus.rd_used = 2'b11;
        #2;
        n_chk++; if (bus.rd[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rd0 got %h exp 0", bus.rd[0]); end
        n_chk++; if (bus.rd[1] !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp 0", bus.rd[1]); end
        n_chk++; if (bus.busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b exp 00", bus.busy); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    endtask

    task automatic test_single_write();
        logic [XLEN-1:0] exp_same;
        exp_same = (BYPASS != 0) ? 32'hAAAAAAAA : 32'h0;
        cyc();
        idle();
        bus.we[0] = 1'b1;
        bus.wa[0] = 5'd1;
        bus.wd[0] = 32'hAAAAAAAA;
        bus.ra[0] = 5'd0;
        bus.ra[1] = 5'd1;
        #2;
        n_chk++; if (bus.rd[1] !== exp_same) begin n_fail++; $display("FAIL wr_bypass got %h exp %h", bus.rd[1], exp_same); end
        cyc();
        bus.we = '0;
        #2;
        n_chk++; if (bus.rd[1] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL wr_stored got %h exp aaaaaaaa", bus.rd[1]); end
        n_chk++; if (bus.rd[0] !== 32'h0) begin n_fail++; $display("FAIL wr_x0_untouched got %h exp 0", bus.rd[0]); end
    endtask

    task automatic test_collision();
        cyc();
        idle();
        bus.we    = 2'b11;
        bus.wa[0] = 5'd2;
        bus.wa[1] = 5'd2;
        bus.wd[0] = 32'hA00AA00A;
        bus.wd[1] = 32'hBBBBBBBB;
        bus.ra[0] = 5'd2;
        bus.ra[1] = 5'd1;
        #2;
        n_chk++; if (bus.rd[0] !== 32'hA00AA00A) begin n_fail++; $display("FAIL coll_bypass got %h exp a00aa00a", bus.rd[0]); end
        n_chk++; if (bus.rd[1] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL coll_other got %h exp aaaaaaaa", bus.rd[1]); end
        cyc();
        bus.we = '0;
        #2;
        n_chk++; if (bus.rd[0] !== 32'hA00AA00A) begin n_fail++; $display("FAIL coll_stored got %h exp a00aa00a", bus.rd[0]); end
        // Port 1 alone to a different register must still land.
        cyc();
        bus.we    = 2'b10;
        bus.wa[1] = 5'd3;
        bus.wd[1] = 32'h13572468;
        cyc();
        bus.we    = '0;
        bus.ra[1] = 5'd3;
        #2;
        n_chk++; if (bus.rd[1] !== 32'h13572468) begin n_fail++; $display("FAIL port1_write got %h exp 13572468", bus.rd[1]); end
    endtask

    task automatic test_zero_reg();
        cyc();
        idle();
        bus.we    = 2'b11;
        bus.wa[0] = 5'd0;
        bus.wa[1] = 5'd0;
        bus.wd[0] = 32'hFFFFFFFF;
        bus.wd[1] = 32'hFFFFFFFF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.ra[0] = 5'd0;
        bus.ra[1] = 5'd0;
        bus.rd_used = 2'b11;
        #2;
        n_chk++; if (bus.rd[0] !== 32'h0) begin n_fail++; $display("FAIL x0_no_bypass got %h exp 0", bus.rd[0]); end
        cyc();
        bus.we = '0;
        bus.issue_valid = 1'b0;
        #2;
        n_chk++; if (bus.rd[1] !== 32'h0) begin n_fail++; $display("FAIL x0_stored got %h exp 0", bus.rd[1]); end
        n_chk++; if (bus.busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy got %b exp 00", bus.busy); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b exp 0", bus.stall); end
    endtask

    task automatic test_scoreboard();
        cyc();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        bus.ra[0]       = 5'd5;
        bus.rd_used     = 2'b01;
        #2;
        n_chk++; if (bus.busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_not_yet got %b exp 0", bus.busy[0]); end
        cyc();
        bus.issue_valid = 1'b0;
        #2;
        n_chk++; if (bus.busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_busy got %b exp 1", bus.busy[0]); end
        n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall got %b exp 1", bus.stall); end
        bus.rd_used = 2'b10;
        #1;
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sb_unused_stall got %b exp 0", bus.stall); end
        bus.rd_used = 2'b01;
        bus.we[1]   = 1'b1;
        bus.wa[1]   = 5'd5;
        bus.wd[1]   = 32'h12345678;
        #1;
        n_chk++; if (bus.busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_wb_bypass_busy got %b exp 0", bus.busy[0]); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sb_wb_bypass_stall got %b exp 0", bus.stall); end
        n_chk++; if (bus.rd[0] !== 32'h12345678) begin n_fail++; $display("FAIL sb_wb_bypass_rd got %h exp 12345678", bus.rd[0]); end
        cyc();
        bus.we = '0;
        #2;
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sb_after_wb_stall got %b exp 0", bus.stall); end
        n_chk++; if (bus.rd[0] !== 32'h12345678) begin n_fail++; $display("FAIL sb_after_wb_rd got %h exp 12345678", bus.rd[0]); end
    endtask

    task automatic test_port0_no_clear();
        cyc();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        cyc();
        bus.issue_valid = 1'b0;
        bus.we[0] = 1'b1;
        bus.wa[0] = 5'd6;
        bus.wd[0] = 32'h00000066;
        bus.ra[1] = 5'd6;
        bus.rd_used = 2'b10;
        #2;
        n_chk++; if (bus.busy[1] !== 1'b1) begin n_fail++; $display("FAIL p0_same_cycle_busy got %b exp 1", bus.busy[1]); end
        cyc();
        bus.we = '0;
        #2;
        n_chk++; if (bus.busy[1] !== 1'b1) begin n_fail++; $display("FAIL p0_no_clear got %b exp 1", bus.busy[1]); end
        // Re-issue keeps a single pending bit: one Writeback retires it.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        cyc();
        bus.issue_valid = 1'b0;
        bus.we[1] = 1'b1;
        bus.wa[1] = 5'd6;
        bus.wd[1] = 32'h00000067;
        cyc();
        bus.we = '0;
        #2;
        n_chk++; if (bus.busy[1] !== 1'b0) begin n_fail++; $display("FAIL reissue_clear got %b exp 0", bus.busy[1]); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reissue_stall got %b exp 0", bus.stall); end
    endtask

    task automatic test_race_and_reset();
        cyc();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        bus.we[1] = 1'b1;
        bus.wa[1] = 5'd5;
        bus.wd[1] = 32'hCAFEF00D;
        cyc();
        idle();
        bus.ra[0]   = 5'd5;
        bus.ra[1]   = 5'd2;
        bus.rd_used = 2'b01;
        #2;
        n_chk++; if (bus.busy[0] !== 1'b1) begin n_fail++; $display("FAIL race_set_wins got %b exp 1", bus.busy[0]); end
        n_chk++; if (bus.rd[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL race_data got %h exp cafef00d", bus.rd[0]); end
        reset = 1'b0;
        bus.we[0] = 1'b1;
        bus.wa[0] = 5'd7;
        bus.wd[0] = 32'h77777777;
        cyc();
        reset = 1'b1;
        idle();
        bus.ra[0]   = 5'd5;
        bus.ra[1]   = 5'd2;
        bus.rd_used = 2'b11;
        #2;
        n_chk++; if (bus.busy !== 2'b00) begin n_fail++; $display("FAIL rst2_busy got %b exp 00", bus.busy); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst2_stall got %b exp 0", bus.stall); end
        n_chk++; if (bus.rd[0] !== 32'h0) begin n_fail++; $display("FAIL rst2_x5 got %h exp 0", bus.rd[0]); end
        n_chk++; if (bus.rd[1] !== 32'h0) begin n_fail++; $display("FAIL rst2_x2 got %h exp 0", bus.rd[1]); end
        bus.ra[0] = 5'd7;
        #1;
        n_chk++; if (bus.rd[0] !== 32'h0) begin n_fail++; $display("FAIL rst2_x7 got %h exp 0", bus.rd[0]); end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_single_write();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_port0_no_clear();
        test_race_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
